// File: rtl/rf_pkg.sv
// Shared widths, protected-range constants and requester ids for rf_arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

    localparam int RF_DEPTH = 16;
    localparam int RF_DW    = 8;
    localparam int RF_AW    = 4;

    localparam logic [RF_AW-1:0] PROT_ADDR_LO = 4'd14;
    localparam logic [RF_AW-1:0] PROT_ADDR_HI = 4'd15;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    // Protected window is exactly the two top entries; equality tests
    // avoid a relational compare that is constant-true at the top end.
    function automatic logic is_prot_addr(input logic [RF_AW-1:0] addr);
        return (addr == PROT_ADDR_LO) || (addr == PROT_ADDR_HI);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Latency: grant is combinational from valid; pointer moves at the edge after a grant.
// Backpressure: a requester that is not granted simply holds valid; it wins within 2 cycles.
//
// Ports: clk, reset (sync, active-high), valid[1:0] requests, grant[1:0] one-hot grant.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_id_t prio;

    // No grants while reset is held so nothing handshakes during reset.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (valid == 2'b11) begin
                grant = (prio == REQ0) ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    // Priority passes to the other requester after every completed grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= REQ0;
        end else if (grant[0]) begin
            prio <= REQ1;
        end else if (grant[1]) begin
            prio <= REQ0;
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two write and two read requesters onto a 1W/1R register file.
// Latency: write/read grants combinational; read data and rd_rvalid registered, 1 cycle.
// Backpressure: wr_ready/rd_ready are the grants; losers hold valid and win next cycle.
//
// Ports: clk, reset (sync, active-high); wr_valid/wr_addr/wr_data -> wr_ready;
//        rd_valid/rd_addr -> rd_ready, rd_rvalid/rd_rdata; rf_we/rf_ptr_w/rf_di write port;
//        rf_ptr_a/rf_do_a read port; err_prot/err_src sticky protected-write error.
module rf_arbiter
    import rf_pkg::*;
#(
    parameter bit PROT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             wr_valid,
    input  logic [1:0][RF_AW-1:0]  wr_addr,
    input  logic [1:0][RF_DW-1:0]  wr_data,
    output logic [1:0]             wr_ready,
    input  logic [1:0]             rd_valid,
    input  logic [1:0][RF_AW-1:0]  rd_addr,
    output logic [1:0]             rd_ready,
    output logic [1:0]             rd_rvalid,
    output logic [RF_DW-1:0]       rd_rdata,
    output logic                   rf_we,
    output logic [RF_AW-1:0]       rf_ptr_w,
    output logic [RF_DW-1:0]       rf_di,
    output logic [RF_AW-1:0]       rf_ptr_a,
    input  logic [RF_DW-1:0]       rf_do_a,
    output logic                   err_prot,
    output logic [1:0]             err_src
);

    logic [1:0] wr_gnt;
    logic [1:0] rd_gnt;
    logic       wr_sel;
    logic       rd_sel;
    logic       wr_prot;

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .valid (wr_valid),
        .grant (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .valid (rd_valid),
        .grant (rd_gnt)
    );

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    // Grants are one-hot, so bit 1 alone selects the winning lane.
    assign wr_sel  = wr_gnt[1];
    assign rd_sel  = rd_gnt[1];
    assign wr_prot = PROT_EN && is_prot_addr(wr_addr[wr_sel]);

    // A protected write still handshakes but never reaches the write port;
    // the port stays all-zero whenever nothing is being written.
    always_comb begin
        rf_we    = 1'b0;
        rf_ptr_w = '0;
        rf_di    = '0;
        if ((|wr_gnt) && !wr_prot) begin
            rf_we    = 1'b1;
            rf_ptr_w = wr_addr[wr_sel];
            rf_di    = wr_data[wr_sel];
        end
    end

    always_comb begin
        rf_ptr_a = '0;
        if (|rd_gnt) begin
            rf_ptr_a = rd_addr[rd_sel];
        end
    end

    // rf_do_a reflects the array before this cycle's write lands, so a
    // same-cycle read of the written address returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rvalid <= 2'b00;
            rd_rdata  <= '0;
            err_prot  <= 1'b0;
            err_src   <= 2'b00;
        end else begin
            rd_rvalid <= rd_gnt;
            if (|rd_gnt) begin
                rd_rdata <= rf_do_a;
            end
            if ((|wr_gnt) && wr_prot) begin
                err_prot <= 1'b1;
                err_src  <= err_src | wr_gnt;
            end
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter: round-robin, read/write ordering, protection, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      wr_valid;
    logic [1:0][3:0] wr_addr;
    logic [1:0][7:0] wr_data;
    logic [1:0]      rd_valid;
    logic [1:0][3:0] rd_addr;

    logic [1:0] wr_ready, rd_ready, rd_rvalid, err_src;
    logic [7:0] rd_rdata, rf_di, rf_do_a;
    logic [3:0] rf_ptr_w, rf_ptr_a;
    logic       rf_we, err_prot;

    logic [1:0] wr_ready2, rd_ready2, rd_rvalid2, err_src2;
    logic [7:0] rd_rdata2, rf_di2;
    logic [7:0] rf_do_a2 = 8'h00;
    logic [3:0] rf_ptr_w2, rf_ptr_a2;
    logic       rf_we2, err_prot2;

    logic [7:0] mem [16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_arbiter #(.PROT_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .rf_we(rf_we), .rf_ptr_w(rf_ptr_w), .rf_di(rf_di),
        .rf_ptr_a(rf_ptr_a), .rf_do_a(rf_do_a),
        .err_prot(err_prot), .err_src(err_src)
    );

    rf_arbiter #(.PROT_EN(1'b0)) dut_noprot (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready2),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready2),
        .rd_rvalid(rd_rvalid2), .rd_rdata(rd_rdata2),
        .rf_we(rf_we2), .rf_ptr_w(rf_ptr_w2), .rf_di(rf_di2),
        .rf_ptr_a(rf_ptr_a2), .rf_do_a(rf_do_a2),
        .err_prot(err_prot2), .err_src(err_src2)
    );

    // Register file attached to the protected instance.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (rf_we) mem[rf_ptr_w] <= rf_di;
    end
    assign rf_do_a = mem[rf_ptr_a];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        wr_valid = 2'b11;
        rd_valid = 2'b11;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;

        // ---- reset state: requests present but nothing handshakes
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 2'b00);
        chk("rst_rd_ready", rd_ready, 2'b00);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rvalid", rd_rvalid, 2'b00);
        chk("rst_rdata", rd_rdata, 8'h00);
        chk("rst_err", {err_prot, err_src}, 3'b000);
        chk("rst2_rd_ready", rd_ready2, 2'b00);
        chk("rst2_ptr_a", rf_ptr_a2, 4'h0);
        chk("rst2_rvalid", {rd_rvalid2, rd_rdata2}, 10'h000);

        // ---- round-robin writes: both requesters, addr 3/5, data 11/22
        reset      = 1'b0;
        rd_valid   = 2'b00;
        wr_valid   = 2'b11;
        wr_addr[0] = 4'd3; wr_data[0] = 8'h11;
        wr_addr[1] = 4'd5; wr_data[1] = 8'h22;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("rr_wr_ready", wr_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rf_we", rf_we, 1'b1);
            chk("rr_ptr_w", rf_ptr_w, (k % 2 == 0) ? 4'd3 : 4'd5);
            chk("rr_di", rf_di, (k % 2 == 0) ? 8'h11 : 8'h22);
        end
        @(negedge clk);
        idle();
        #1;
        chk("idle_rf_we", rf_we, 1'b0);
        chk("idle_ptr_w", rf_ptr_w, 4'h0);
        chk("idle_di", rf_di, 8'h00);
        chk("idle_ptr_a", rf_ptr_a, 4'h0);
        chk("mem3", mem[3], 8'h11);
        chk("mem5", mem[5], 8'h22);

        // ---- same-cycle write/read of addr 7 returns old data, next read new
        @(negedge clk);
        wr_valid   = 2'b01; wr_addr[0] = 4'd7; wr_data[0] = 8'hA5;
        rd_valid   = 2'b10; rd_addr[1] = 4'd7;
        #1;
        chk("raw_rd_ready", rd_ready, 2'b10);
        chk("raw_ptr_a", rf_ptr_a, 4'd7);
        chk("raw_rf_we", rf_we, 1'b1);
        @(negedge clk);
        chk("raw_rvalid0", rd_rvalid, 2'b10);
        chk("raw_rdata_old", rd_rdata, 8'h00);
        wr_valid = 2'b00;
        #1;
        chk("raw_rd_ready2", rd_ready, 2'b10);
        @(negedge clk);
        chk("raw_rvalid1", rd_rvalid, 2'b10);
        chk("raw_rdata_new", rd_rdata, 8'hA5);
        idle();
        @(negedge clk);
        chk("raw_rvalid_pulse", rd_rvalid, 2'b00);

        // ---- protected write from requester 1
        wr_valid   = 2'b10; wr_addr[1] = 4'd15; wr_data[1] = 8'hFF;
        #1;
        chk("prot_wr_ready", wr_ready, 2'b10);
        chk("prot_rf_we", rf_we, 1'b0);
        chk("noprot_wr_ready", wr_ready2, 2'b10);
        chk("noprot_rf_we", rf_we2, 1'b1);
        chk("noprot_ptr_w", rf_ptr_w2, 4'd15);
        chk("noprot_di", rf_di2, 8'hFF);
        @(negedge clk);
        idle();
        chk("prot_err", {err_prot, err_src}, 3'b110);
        chk("noprot_err", {err_prot2, err_src2}, 3'b000);
        @(negedge clk);
        chk("prot_err_sticky", {err_prot, err_src}, 3'b110);
        chk("prot_mem15", mem[15], 8'h00);

        // ---- reset with a read response pending
        wr_valid   = 2'b01; wr_addr[0] = 4'd2; wr_data[0] = 8'h33;
        rd_valid   = 2'b01; rd_addr[0] = 4'd3;
        #1;
        chk("pre_rst_grants", {wr_ready, rd_ready}, 4'b0101);
        @(negedge clk);
        chk("pre_rst_rvalid", rd_rvalid, 2'b01);
        chk("pre_rst_rdata", rd_rdata, 8'h11);
        reset    = 1'b1;
        wr_valid = 2'b00;
        #1;
        chk("in_rst_rd_ready", rd_ready, 2'b00);
        @(negedge clk);
        chk("post_rst_rvalid", rd_rvalid, 2'b00);
        chk("post_rst_rdata", rd_rdata, 8'h00);
        chk("post_rst_err", {err_prot, err_src}, 3'b000);
        reset      = 1'b0;
        wr_valid   = 2'b11;
        wr_addr[0] = 4'd1; wr_data[0] = 8'h44;
        wr_addr[1] = 4'd2; wr_data[1] = 8'h55;
        rd_valid   = 2'b11;
        rd_addr[0] = 4'd3; rd_addr[1] = 4'd5;
        #1;
        chk("rel_wr_ready", wr_ready, 2'b01);
        chk("rel_rd_ready", rd_ready, 2'b01);
        chk("rel_ptr_w", rf_ptr_w, 4'd1);
        chk("rel_ptr_a", rf_ptr_a, 4'd3);

        // ---- req0 streams 8 reads, req1 asks once at cycle 2
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c > 0) chk("strm_rvalid", rd_rvalid, (c == 3) ? 2'b10 : 2'b01);
            chk("strm_rvalid_onehot", rd_rvalid == 2'b11, 1'b0);
            if (c == 2) chk("strm_rdata_a1", rd_rdata, 8'h44);
            if (c == 3) chk("strm_rdata_req1", rd_rdata, 8'h22);
            wr_valid   = 2'b00;
            rd_valid   = {(c == 2), 1'b1};
            rd_addr[0] = 4'(c);
            rd_addr[1] = 4'd5;
            #1;
            chk("strm_rd_ready", rd_ready, (c == 2) ? 2'b10 : 2'b01);
        end
        @(negedge clk);
        idle();
        chk("strm_last_rvalid", rd_rvalid, 2'b01);
        chk("strm_last_rdata", rd_rdata, 8'h00);
        @(negedge clk);
        chk("strm_done_rvalid", rd_rvalid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter: PROT_EN, 1, when 1 writes to protected addresses 14/15 are dropped and flagged.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: wr_valid  in  2  per-requester write request.
REQ-005 Port: wr_addr  in  2x4  per-requester write address.
REQ-006 Port: wr_data  in  2x8  per-requester write data.
REQ-007 Port: wr_ready  out  2  write accepted this cycle.
REQ-008 Port: rd_valid  in  2  per-requester read request.
REQ-009 Port: rd_addr  in  2x4  per-requester read address.
REQ-010 Port: rd_ready  out  2  read accepted this cycle.
REQ-011 Port: rd_rvalid  out  2  registered read response strobe.
REQ-012 Port: rd_rdata  out  8  registered read data, meaningful only while a rd_rvalid bit is high.
REQ-013 Port: rf_we, rf_ptr_w, rf_di  out  1/4/8  to the register-file write port.
REQ-014 Port: rf_ptr_a  out  4  register-file read address; rf_do_a  in  8  combinational read data.
REQ-015 Port: err_prot  out  1  sticky protected-write error; err_src  out  2  sticky per-requester error source.

Function
REQ-016 Write and read ports SHALL be arbitrated independently; at most one write and one read grant per cycle.
REQ-017 Each arbiter SHALL be 2-way round-robin: after a grant to requester i, priority passes to requester 1-i; a lone requester is always granted.
REQ-018 Grants SHALL be combinational from valid and the registered priority pointer; wr_ready/rd_ready equal the grant; the pointer updates only on a completed grant.
REQ-019 On a write grant: rf_ptr_w/rf_di = granted addr/data, rf_we=1, unless the write is protected (REQ-022).
REQ-020 With no write grant: rf_we=0, rf_ptr_w=0, rf_di=0; with no read grant: rf_ptr_a=0.
REQ-021 On a read grant, rf_ptr_a = granted rd_addr; rf_do_a is captured into rd_rdata and rd_rvalid[i] is set at the next edge (1-cycle latency), held for exactly one cycle.
REQ-022 Protected write (PROT_EN=1, addr 14 or 15): handshake completes (wr_ready=1), rf_we=0, err_prot and err_src[i] set at next edge and held until reset.
REQ-023 Read and write to the same address in the same cycle SHALL return pre-write data; a read granted the cycle after the write returns new data; no bypass.
REQ-024 Back-to-back grants are allowed every cycle; throughput of one write plus one read per cycle.
REQ-025 A requester holding valid SHALL be granted within 2 cycles (no starvation).
REQ-026 Both rd_rvalid bits SHALL never be high simultaneously.

Reset
REQ-027 While reset=1: wr_ready=0, rd_ready=0, rf_we=0, all rf_* outputs 0, no pointer update.
REQ-028 At the edge with reset=1: both priority pointers -> requester 0; rd_rvalid=0; rd_rdata=0; err_prot=0; err_src=0.
REQ-029 Reset asserted with a read response pending SHALL drop it (rd_rvalid=0 next cycle); requests are re-arbitrated from scratch after release.

Structure
REQ-030 Package rf_pkg SHALL hold RF_DEPTH=16, RF_DW=8, RF_AW=4, PROT_ADDR_LO=14, PROT_ADDR_HI=15, and the req_id_t enum (REQ0, REQ1).
REQ-031 Sub-module rr_arb2 (2-way round-robin with registered pointer, clk/reset/valid/grant) SHALL be instantiated twice, once for writes and once for reads.

Verification
REQ-032 Both wr_valid high for 4 cycles after reset, addrs 3/5, data 0x11/0x22 -> grants 0,1,0,1; rf writes 3<-0x11, 5<-0x22 alternately.
REQ-033 Write addr 7 data 0xA5 (req0) with same-cycle read addr 7 (req1, old value 0x00) -> rd_rdata=0x00; read next cycle -> 0xA5, rd_rvalid[1] one cycle after each grant.
REQ-034 Req1 writes addr 15 data 0xFF -> wr_ready[1]=1, rf_we=0, err_prot=1, err_src=2'b10 sticky; PROT_EN=0 -> rf_we=1, no error.
REQ-035 Read granted, reset asserted next cycle -> rd_rvalid=0, pointers reset, err flags cleared; first request after release goes to requester 0.
REQ-036 Req0 streams 8 consecutive reads while req1 raises rd_valid once -> req1 granted within 2 cycles, req0 resumes.
